// File: rtl/ilm_pkg.sv
// ============================================================================
// ilm_pkg : shared constants, state encoding and term helper for ilm_iter_mult
// Revision: 1.0
// ============================================================================
`default_nettype none

package ilm_pkg;

  localparam int OP_WIDTH = 16;
  localparam int PWIDTH   = 32;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TERM = 2'd1,
    DONE = 2'd2
  } state_t;

  // One ILM term: 2^(k1+k2) + res1*2^k2 + res2*2^k1, all at product width.
  function automatic logic [PWIDTH-1:0] ilm_term(
    input logic [OP_WIDTH-1:0] res1,
    input logic [OP_WIDTH-1:0] res2,
    input logic [3:0]          k1,
    input logic [3:0]          k2
  );
    logic [PWIDTH-1:0] t;
    t = (PWIDTH'(1) << ({1'b0, k1} + {1'b0, k2}))
      + ({{(PWIDTH-OP_WIDTH){1'b0}}, res1} << k2)
      + ({{(PWIDTH-OP_WIDTH){1'b0}}, res2} << k1);
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_32bits.sv
// ============================================================================
// adder_32bits : 32-bit carry-select adder built from 4-bit blocks
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_32bits (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_ci,
  output logic [31:0] o_s,
  output logic        o_co
);

  localparam int C_BLK  = 4;
  localparam int C_NBLK = 8;

  logic [C_NBLK:0] w_c;

  assign w_c[0] = i_ci;

  // Each block precomputes both carry-in outcomes; the ripple is only through muxes.
  for (genvar gi = 0; gi < C_NBLK; gi++) begin : g_blk
    logic [C_BLK:0] w_s0;
    logic [C_BLK:0] w_s1;
    assign w_s0 = {1'b0, i_a[gi*C_BLK +: C_BLK]} + {1'b0, i_b[gi*C_BLK +: C_BLK]};
    assign w_s1 = {1'b0, i_a[gi*C_BLK +: C_BLK]} + {1'b0, i_b[gi*C_BLK +: C_BLK]}
                + (C_BLK+1)'(1);
    assign {w_c[gi+1], o_s[gi*C_BLK +: C_BLK]} = w_c[gi] ? w_s1 : w_s0;
  end

  assign o_co = w_c[C_NBLK];

endmodule

`default_nettype wire

// File: rtl/lod_16.sv
// ============================================================================
// lod_16 : combinational leading-one detector for a 16-bit word
// Revision: 1.0
// ============================================================================
`default_nettype none

module lod_16 (
  input  logic [15:0] i_val,
  output logic [3:0]  o_pos,
  output logic        o_zero
);

  always_comb begin
    o_pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i_val[i]) o_pos = 4'(i);
    end
  end

  assign o_zero = ~|i_val;

endmodule

`default_nettype wire

// File: rtl/ilm_iter_mult.sv
// ============================================================================
// ilm_iter_mult : iterative improved logarithmic multiplier, one term per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module ilm_iter_mult
  import ilm_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX_ITER);

  state_t              r_state;
  logic [WIDTH-1:0]    r_r1;
  logic [WIDTH-1:0]    r_r2;
  logic [PWIDTH-1:0]   r_acc;
  logic [PWIDTH-1:0]   r_p;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_out_valid;
  logic                r_in_ready;
  logic                r_busy;

  logic [3:0]          w_k1;
  logic [3:0]          w_k2;
  logic                w_z1;
  logic                w_z2;
  logic [WIDTH-1:0]    w_res1;
  logic [WIDTH-1:0]    w_res2;
  logic [PWIDTH-1:0]   w_term;
  logic [PWIDTH-1:0]   w_sum;
  logic                w_unused_co;

  lod_16 u_lod1 (.i_val(r_r1), .o_pos(w_k1), .o_zero(w_z1));
  lod_16 u_lod2 (.i_val(r_r2), .o_pos(w_k2), .o_zero(w_z2));

  assign w_res1 = r_r1 ^ (WIDTH'(1) << w_k1);
  assign w_res2 = r_r2 ^ (WIDTH'(1) << w_k2);
  assign w_term = ilm_term(w_res1, w_res2, w_k1, w_k2);

  // Terms never overshoot a*b, so the carry-out is structurally always zero.
  adder_32bits u_adder (
    .i_a  (r_acc),
    .i_b  (w_term),
    .i_ci (1'b0),
    .o_s  (w_sum),
    .o_co (w_unused_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_r1        <= '0;
      r_r2        <= '0;
      r_acc       <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_r1       <= a;
            r_r2       <= b;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= TERM;
          end
        end
        TERM: begin
          if (w_z1 || w_z2) begin
            r_state <= DONE;
          end else begin
            r_acc <= w_sum;
            r_r1  <= w_res1;
            r_r2  <= w_res2;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) r_state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle registers the product; afterwards wait for the consumer.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_p         <= r_acc;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign p         = r_p;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ilm_iter_mult.sv
// ============================================================================
// tb_ilm_iter_mult : self-checking bench, three instances (MAX_ITER 0, 1, 15)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ilm_iter_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic [15:0] a_s         [3];
  logic [15:0] b_s         [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic [31:0] p_s         [3];
  logic        busy_s      [3];
  logic        co_mon      [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int MI = (gi == 0) ? 0 : ((gi == 1) ? 1 : 15);
    ilm_iter_mult #(.WIDTH(16), .MAX_ITER(MI)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[gi]),
      .in_ready  (in_ready_s[gi]),
      .a         (a_s[gi]),
      .b         (b_s[gi]),
      .out_valid (out_valid_s[gi]),
      .out_ready (out_ready_s[gi]),
      .p         (p_s[gi]),
      .busy      (busy_s[gi])
    );
    assign co_mon[gi] = u_dut.w_unused_co;
  end

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_p;
    int          exp_lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int mi_of(input int inst);
    return (inst == 0) ? 0 : ((inst == 1) ? 1 : 15);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int msb16(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model(input logic [15:0] a, input logic [15:0] b, input int mi,
                       output logic [31:0] pr, output int n);
    logic [15:0] r1;
    logic [15:0] r2;
    int          k1;
    int          k2;
    bit          done;
    r1 = a; r2 = b; pr = '0; n = 0; done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      n++;
      if (r1 == 0 || r2 == 0) begin
        done = 1'b1;
      end else begin
        k1 = msb16(r1);
        k2 = msb16(r2);
        r1 = r1 ^ (16'd1 << k1);
        r2 = r2 ^ (16'd1 << k2);
        pr = pr + (32'd1 << (k1 + k2)) + ({16'd0, r1} << k2) + ({16'd0, r2} << k1);
        if (c == mi) done = 1'b1;
      end
    end
  endtask

  task automatic run_op(input int inst, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input int exp_lat, input int hold);
    int   w;
    int   lat;
    exp_t e;
    w = 0;
    while (!in_ready_s[inst] && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", 32'(in_ready_s[inst]), 32'd1);
    in_valid_s[inst] = 1'b1;
    a_s[inst] = a;
    b_s[inst] = b;
    @(posedge clk);
    sb.push_back('{p: exp_p, lat: exp_lat});
    @(negedge clk);
    in_valid_s[inst] = 1'b0;
    a_s[inst] = 16'($urandom);
    b_s[inst] = 16'($urandom);
    check("busy_after_accept", 32'(busy_s[inst]), 32'd1);
    lat = 0;
    while (!out_valid_s[inst] && lat < 40) begin
      check("adder_co", 32'(co_mon[inst]), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("out_valid_timeout", 32'(out_valid_s[inst]), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("product", p_s[inst], e.p);
    check("latency", 32'(lat), 32'(e.lat));
    check("in_ready_in_done", 32'(in_ready_s[inst]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid_s[inst] = 1'b1;
      a_s[inst] = 16'hFFFF;
      b_s[inst] = 16'hFFFF;
      @(negedge clk);
      check("hold_product", p_s[inst], e.p);
      check("hold_out_valid", 32'(out_valid_s[inst]), 32'd1);
      check("hold_in_ready", 32'(in_ready_s[inst]), 32'd0);
    end
    in_valid_s[inst]  = 1'b0;
    out_ready_s[inst] = 1'b1;
    @(negedge clk);
    out_ready_s[inst] = 1'b0;
    check("out_valid_drop", 32'(out_valid_s[inst]), 32'd0);
    check("in_ready_rise", 32'(in_ready_s[inst]), 32'd1);
    check("busy_drop", 32'(busy_s[inst]), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] mp;
    int          mn;

    tbl[0]  = '{0, 16'd3,     16'd3,     32'd8,          2,  0};
    tbl[1]  = '{1, 16'd3,     16'd3,     32'd9,          3,  0};
    tbl[2]  = '{2, 16'd3,     16'd3,     32'd9,          4,  0};
    tbl[3]  = '{0, 16'd65535, 16'd65535, 32'd3221159936, 2,  0};
    tbl[4]  = '{2, 16'd65535, 16'd65535, 32'd4294836225, 17, 0};
    tbl[5]  = '{0, 16'd0,     16'd1234,  32'd0,          2,  0};
    tbl[6]  = '{2, 16'd0,     16'd1234,  32'd0,          2,  0};
    tbl[7]  = '{0, 16'd1,     16'd1,     32'd1,          2,  0};
    tbl[8]  = '{1, 16'd1,     16'd1,     32'd1,          3,  0};
    tbl[9]  = '{2, 16'd1,     16'd1,     32'd1,          3,  0};
    tbl[10] = '{1, 16'd3,     16'd3,     32'd9,          3,  5};
    tbl[11] = '{2, 16'd5,     16'd6,     32'd30,         4,  0};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b0;
      a_s[i]         = '0;
      b_s[i]         = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_in_ready",  32'(in_ready_s[i]),  32'd1);
      check("reset_out_valid", 32'(out_valid_s[i]), 32'd0);
      check("reset_busy",      32'(busy_s[i]),      32'd0);
      check("reset_p",         p_s[i],              32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].inst, tbl[i].a, tbl[i].b, tbl[i].exp_p, tbl[i].exp_lat, tbl[i].hold);

    for (int inst = 0; inst < 3; inst++) begin
      for (int k = 0; k < 6; k++) begin
        ra = 16'($urandom);
        rb = (k == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
        model(ra, rb, mi_of(inst), mp, mn);
        run_op(inst, ra, rb, mp, mn + 1, 0);
      end
    end

    // Abort mid-operation: no product may appear for the killed request.
    in_valid_s[2] = 1'b1;
    a_s[2] = 16'd1000;
    b_s[2] = 16'd999;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[2] = 1'b0;
    @(negedge clk);
    check("busy_before_abort", 32'(busy_s[2]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid_s[2]), 32'd0);
    check("abort_p",         p_s[2],              32'd0);
    check("abort_in_ready",  32'(in_ready_s[2]),  32'd1);
    check("abort_busy",      32'(busy_s[2]),      32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_output", 32'(out_valid_s[2]), 32'd0);
    end
    run_op(2, 16'd5, 16'd6, 32'd30, 4, 0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
